// File: rtl/fpu_req_arbiter.sv
// Purpose : round-robin arbiter/issue scheduler sharing one pipelined FPU between NUM_REQ requesters.
// Latency : operands registered on the grant edge E0; response strobe in the cycle after edge E0+FPU_LAT+1.
// Backpress: combinational one-hot valid/ready grant; responses have no backpressure (accept on strobe).
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready        per-requester handshake, req_ready is combinational one-hot
//   req_opa/opb/op/rmode       packed payloads, requester i in slice i
//   fpu_opa/opb/op/rmode       registered operands to the FPU
//   fpu_result/fpu_flags       FPU outputs, valid FPU_LAT edges after operands register
//   rsp_valid/result/flags     one-hot strobe plus shared registered result/flag buses
//   flush_req/flush_done       stop issue, drain, report drained
//   busy                       any operation in flight
//   grant_cnt                  per-requester 16-bit saturating transfer counters
//                              (only when FPU_ARB_STATS_EN is defined)
module fpu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int FPU_LAT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_opa,
  input  logic [NUM_REQ*DATA_W-1:0] req_opb,
  input  logic [NUM_REQ*3-1:0]      req_op,
  input  logic [NUM_REQ*2-1:0]      req_rmode,
  output logic [DATA_W-1:0]         fpu_opa,
  output logic [DATA_W-1:0]         fpu_opb,
  output logic [2:0]                fpu_op,
  output logic [1:0]                fpu_rmode,
  input  logic [DATA_W-1:0]         fpu_result,
  input  logic [7:0]                fpu_flags,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_result,
  output logic [7:0]                rsp_flags,
  input  logic                      flush_req,
  output logic                      flush_done,
`ifdef FPU_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]     grant_cnt,
`endif
  output logic                      busy
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int NSTG = FPU_LAT + 1;
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  // One-hot encoding so flush_done is a flop bit, not decoded logic.
  typedef enum logic [2:0] {
    ST_RUN     = 3'b001,
    ST_DRAIN   = 3'b010,
    ST_FLUSHED = 3'b100
  } state_t;

  state_t              state_q, state_d;
  logic                issue_en;
  logic [IDW-1:0]      rr_ptr_q;
  logic [IDW:0]        cand;
  logic                gnt_found;
  logic [IDW-1:0]      gnt_idx;
  logic                xfer;
  logic [DATA_W-1:0]   fpu_opa_q, fpu_opb_q;
  logic [2:0]          fpu_op_q;
  logic [1:0]          fpu_rmode_q;
  tag_t                tag_q [NSTG];
  tag_t                tail;
  logic                busy_c;
  logic [NUM_REQ-1:0]  rsp_valid_d, rsp_valid_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic [7:0]          rsp_flags_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (flush_req) state_d = ST_DRAIN;
      ST_DRAIN:   if (!busy_c)   state_d = ST_FLUSHED;
      ST_FLUSHED: if (!flush_req) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // reset gates issue so req_ready is 0 for the whole time reset is held.
  always_comb begin
    issue_en   = (state_q == ST_RUN) && !flush_req && reset;
    flush_done = (state_q == ST_FLUSHED);
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (issue_en && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  // Grant only ever points at a valid requester, so grant implies transfer.
  assign xfer = issue_en && gnt_found;

  // ---------------- issue registers and pointer ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpu_opa_q   <= '0;
      fpu_opb_q   <= '0;
      fpu_op_q    <= '0;
      fpu_rmode_q <= '0;
      rr_ptr_q    <= '0;
    end else if (xfer) begin
      fpu_opa_q   <= req_opa[gnt_idx*DATA_W +: DATA_W];
      fpu_opb_q   <= req_opb[gnt_idx*DATA_W +: DATA_W];
      fpu_op_q    <= req_op[gnt_idx*3 +: 3];
      fpu_rmode_q <= req_rmode[gnt_idx*2 +: 2];
      rr_ptr_q    <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
    end
  end

  // ---------------- owner tag pipeline ----------------
  // Stage 0 aligns with the operand register; the tail lines up with the
  // FPU output being valid, so capturing on tail valid pairs result and owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NSTG; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= '{vld: xfer, id: gnt_idx};
      for (int s = 1; s < NSTG; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign tail = tag_q[NSTG-1];

  always_comb begin
    busy_c = 1'b0;
    for (int s = 0; s < NSTG; s++) busy_c = busy_c | tag_q[s].vld;
  end

  always_comb begin
    rsp_valid_d = '0;
    if (tail.vld) rsp_valid_d[tail.id] = 1'b1;
  end

  // ---------------- response registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (tail.vld) begin
        rsp_result_q <= fpu_result;
        rsp_flags_q  <= fpu_flags;
      end
    end
  end

  assign fpu_opa    = fpu_opa_q;
  assign fpu_opb    = fpu_opb_q;
  assign fpu_op     = fpu_op_q;
  assign fpu_rmode  = fpu_rmode_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = busy_c;

`ifdef FPU_ARB_STATS_EN
  // Counters restart when leaving FLUSHED so each test phase counts from zero.
  logic        stats_clr;
  logic [15:0] cnt_q [NUM_REQ];

  assign stats_clr = (state_q == ST_FLUSHED) && !flush_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr)
          cnt_q[i] <= '0;
        else if (req_valid[i] && req_ready[i] && (cnt_q[i] != 16'hFFFF))
          cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Purpose : directed, table-driven bench for fpu_req_arbiter with a stand-in FPU pipeline.
// Latency : responses expected FPU_LAT+2 cycles after the cycle a grant is expected.
// Backpress: bench drives requests and always accepts responses.
module tb_fpu_req_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int FPU_LAT = 3;
  localparam int RSP_DLY = FPU_LAT + 2;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_opa, req_opb;
  logic [NUM_REQ*3-1:0]      req_op;
  logic [NUM_REQ*2-1:0]      req_rmode;
  logic [DATA_W-1:0]         fpu_opa, fpu_opb, fpu_result;
  logic [2:0]                fpu_op;
  logic [1:0]                fpu_rmode;
  logic [7:0]                fpu_flags;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_result;
  logic [7:0]                rsp_flags;
  logic                      flush_req, flush_done, busy;

  fpu_req_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .FPU_LAT(FPU_LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_op(req_op), .req_rmode(req_rmode),
    .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-requester payloads, packed onto the request buses.
  logic [31:0] opa_a [NUM_REQ];
  logic [31:0] opb_a [NUM_REQ];
  logic [2:0]  op_a  [NUM_REQ];
  logic [1:0]  rm_a  [NUM_REQ];

  always_comb begin
    req_opa = '0; req_opb = '0; req_op = '0; req_rmode = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_opa[i*DATA_W +: DATA_W] = opa_a[i];
      req_opb[i*DATA_W +: DATA_W] = opb_a[i];
      req_op[i*3 +: 3]            = op_a[i];
      req_rmode[i*2 +: 2]         = rm_a[i];
    end
  end

  // Stand-in FPU: known values for the two real operations exercised,
  // an operand signature otherwise so routing errors are visible.
  function automatic logic [39:0] fake_fpu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
    if (op == 3'd3 && b == 32'd0)
      return {32'h7F800000, 8'h81};
    if (op == 3'd0 && a == 32'h3F800000 && b == 32'h40000000)
      return {32'h40400000, 8'h00};
    return {a ^ b ^ {29'd0, op}, {5'd0, op}};
  endfunction

  logic [39:0] fpipe [FPU_LAT];
  always @(posedge clk) begin
    fpipe[0] <= fake_fpu(fpu_opa, fpu_opb, fpu_op);
    for (int k = 1; k < FPU_LAT; k++) fpipe[k] <= fpipe[k-1];
  end
  assign fpu_result = fpipe[FPU_LAT-1][39:8];
  assign fpu_flags  = fpipe[FPU_LAT-1][7:0];

  // Scoreboard of expected responses indexed by cycle number.
  logic [3:0]  sch_v [1024];
  logic [31:0] sch_r [1024];
  logic [7:0]  sch_f [1024];
  int cyc, n_chk, n_pass;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Called at posedge+1 with inputs set; checks grant and response, then
  // advances to posedge+1 of the next cycle.
  task automatic cycle(input logic [3:0] exp_rdy, input string nm);
    logic [39:0] r;
    #2;
    check($sformatf("%s ready @%0d", nm, cyc), 64'(req_ready), 64'(exp_rdy));
    check($sformatf("%s rsp_valid @%0d", nm, cyc), 64'(rsp_valid), 64'(sch_v[cyc]));
    if (sch_v[cyc] != 4'd0) begin
      check($sformatf("%s rsp_result @%0d", nm, cyc), 64'(rsp_result), 64'(sch_r[cyc]));
      check($sformatf("%s rsp_flags @%0d", nm, cyc), 64'(rsp_flags), 64'(sch_f[cyc]));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_rdy[i]) begin
        r = fake_fpu(opa_a[i], opb_a[i], op_a[i]);
        sch_v[cyc+RSP_DLY] = exp_rdy;
        sch_r[cyc+RSP_DLY] = r[39:8];
        sch_f[cyc+RSP_DLY] = r[7:0];
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n, input string nm);
    req_valid = '0;
    for (int k = 0; k < n; k++) cycle(4'b0000, nm);
  endtask

  task automatic check_zero_outputs(input string nm);
    check({nm, " fpu_opa"},    64'(fpu_opa),    64'd0);
    check({nm, " fpu_opb"},    64'(fpu_opb),    64'd0);
    check({nm, " fpu_op"},     64'(fpu_op),     64'd0);
    check({nm, " fpu_rmode"},  64'(fpu_rmode),  64'd0);
    check({nm, " rsp_valid"},  64'(rsp_valid),  64'd0);
    check({nm, " rsp_result"}, 64'(rsp_result), 64'd0);
    check({nm, " rsp_flags"},  64'(rsp_flags),  64'd0);
    check({nm, " flush_done"}, 64'(flush_done), 64'd0);
    check({nm, " busy"},       64'(busy),       64'd0);
    check({nm, " req_ready"},  64'(req_ready),  64'd0);
  endtask

  typedef struct {
    logic [3:0] vld;
    logic [3:0] rdy;
  } vec_t;
  vec_t tbl [17];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    for (int k = 0; k < 1024; k++) begin sch_v[k] = '0; sch_r[k] = '0; sch_f[k] = '0; end
    opa_a[0] = 32'h11110000; opb_a[0] = 32'h00001111; op_a[0] = 3'd2; rm_a[0] = 2'd1;
    opa_a[1] = 32'h3F800000; opb_a[1] = 32'h40000000; op_a[1] = 3'd0; rm_a[1] = 2'd0;
    opa_a[2] = 32'h22220000; opb_a[2] = 32'h00002222; op_a[2] = 3'd1; rm_a[2] = 2'd2;
    opa_a[3] = 32'h33330000; opb_a[3] = 32'h00003333; op_a[3] = 3'd3; rm_a[3] = 2'd3;

    // Round-robin grant table; comment gives rr_ptr after each row.
    for (int k = 0; k < 8; k++) tbl[k] = '{4'b1111, 4'b0001 << (k % 4)}; // ptr 0 at end
    tbl[8]  = '{4'b0000, 4'b0000}; // 0
    tbl[9]  = '{4'b0100, 4'b0100}; // 3
    tbl[10] = '{4'b0011, 4'b0001}; // 1
    tbl[11] = '{4'b0011, 4'b0010}; // 2
    tbl[12] = '{4'b1010, 4'b1000}; // 0
    tbl[13] = '{4'b1010, 4'b0010}; // 2
    tbl[14] = '{4'b1010, 4'b1000}; // 0
    tbl[15] = '{4'b1001, 4'b0001}; // 1
    tbl[16] = '{4'b1001, 4'b1000}; // 0

    reset = 1'b0; flush_req = 1'b0; req_valid = '1;
    @(posedge clk); #1;
    #1 check_zero_outputs("reset");
    for (int k = 0; k < 3; k++) cycle(4'b0000, "in_reset");
    reset = 1'b1;

    for (int k = 0; k < 17; k++) begin
      req_valid = tbl[k].vld;
      cycle(tbl[k].rdy, $sformatf("tbl%0d", k));
    end
    idle(6, "tbl_drain");

    // Single add from requester 1; response strobe exactly FPU_LAT+1 edges after issue.
    req_valid = 4'b0010;
    cycle(4'b0010, "add1");
    req_valid = '0;
    check("add1 fpu_opa",   64'(fpu_opa),   64'h3F800000);
    check("add1 fpu_opb",   64'(fpu_opb),   64'h40000000);
    check("add1 fpu_op",    64'(fpu_op),    64'd0);
    check("add1 fpu_rmode", 64'(fpu_rmode), 64'(rm_a[1]));
    check("add1 busy_on",   64'(busy),      64'd1);
    for (int k = 0; k < 4; k++) cycle(4'b0000, "add1_wait");
    check("add1 busy_off",  64'(busy),      64'd0);
    idle(2, "add1_drain");

    // Divide by zero from requester 2 (rr_ptr is 2 here).
    opb_a[2] = 32'd0; op_a[2] = 3'd3;
    req_valid = 4'b0100;
    cycle(4'b0100, "div0");
    idle(6, "div0_drain");

    // Three back-to-back issues (rr_ptr 3), then flush with requester 2 waiting.
    req_valid = 4'b1111;
    cycle(4'b1000, "fl_a"); cycle(4'b0001, "fl_b"); cycle(4'b0010, "fl_c");
    flush_req = 1'b1; req_valid = 4'b0100;
    cycle(4'b0000, "fl_block");
    check("fl busy_c4", 64'(busy), 64'd1);
    cycle(4'b0000, "fl_drain"); cycle(4'b0000, "fl_drain");
    check("fl busy_c6",       64'(busy),       64'd1);
    check("fl flush_done_c6", 64'(flush_done), 64'd0);
    cycle(4'b0000, "fl_drain");
    check("fl busy_c7",       64'(busy),       64'd0);
    check("fl flush_done_c7", 64'(flush_done), 64'd0);
    cycle(4'b0000, "fl_drain");
    check("fl flush_done_c8", 64'(flush_done), 64'd1);
    cycle(4'b0000, "fl_hold");
    check("fl flush_done_c9", 64'(flush_done), 64'd1);
    flush_req = 1'b0;
    cycle(4'b0000, "fl_release");
    cycle(4'b0100, "fl_regrant");
    check("fl flush_done_c11", 64'(flush_done), 64'd0);
    idle(6, "fl_tail");

    // Reset one cycle after two transfers: in-flight results are dropped.
    req_valid = 4'b1001;
    cycle(4'b1000, "rst_a"); cycle(4'b0001, "rst_b");
    req_valid = 4'b1111;
    reset = 1'b0;
    for (int k = cyc; k < 1024; k++) sch_v[k] = '0;
    #1 check_zero_outputs("mid_reset");
    #1;
    @(posedge clk); #1; cyc++;
    for (int k = 0; k < 3; k++) cycle(4'b0000, "rst_hold");
    reset = 1'b1;
    req_valid = 4'b0110;
    cycle(4'b0010, "post_rst");
    idle(7, "post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fpu_req_arbiter.md
# fpu_req_arbiter

Round-robin arbiter and issue scheduler that shares one pipelined `fpu` datapath between `NUM_REQ` requesters. It sits between the requester ports and the `fpu_interface` operand and rounding/opcode fields. It issues at most one operation per cycle and tracks the owner of every in-flight operation in a tag pipeline. Each result and flag vector is routed back to the requester that issued it. A flush handshake stops issue and drains the FPU for mode changes or test-phase boundaries.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 32: operand/result width (single precision).
- `FPU_LAT`, default 3: FPU latency, ≥1. `fpu_result`/`fpu_flags` reflect operands registered at edge E from edge E+FPU_LAT onward.

Ports:
- `clk`  in  1: clock, all logic on rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: per-requester operation valid.
- `req_ready`  out  NUM_REQ: one-hot grant, combinational.
- `req_opa`, `req_opb`  in  NUM_REQ*DATA_W: packed operands; requester i occupies slice [i*DATA_W +: DATA_W].
- `req_op`  in  NUM_REQ*3: packed `fpu_op` codes.
- `req_rmode`  in  NUM_REQ*2: packed rounding modes.
- `fpu_opa`, `fpu_opb`  out  DATA_W: registered operands to FPU.
- `fpu_op`  out  3: registered opcode.
- `fpu_rmode`  out  2: registered rounding mode.
- `fpu_result`  in  DATA_W: FPU result.
- `fpu_flags`  in  8: {inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero}.
- `rsp_valid`  out  NUM_REQ: one-hot, one-cycle response strobe.
- `rsp_result`  out  DATA_W: shared registered result bus.
- `rsp_flags`  out  8: shared registered flag bus.
- `flush_req`  in  1: request to stop issue and drain.
- `flush_done`  out  1: drain complete, held while `flush_req` stays high.
- `busy`  out  1: any operation in flight.

## Operation
- **Grant.** Issue is enabled when state = RUN and `flush_req` = 0.
  - When enabled, the lowest index ≥ `rr_ptr` (wrapping modulo NUM_REQ) with `req_valid` high gets `req_ready`.
  - Otherwise all `req_ready` are 0.
- **Handshake.** A transfer occurs when `req_valid[i]` & `req_ready[i]` at an edge. The requester must hold its payload stable while valid and not ready.
- **Issue.** On a transfer, the granted slice is registered into `fpu_opa/opb/op/rmode`, and `rr_ptr` ← (i+1) mod NUM_REQ. With no transfer, the `fpu_*` registers and `rr_ptr` hold.
- **Tag pipe.** FPU_LAT+1 stages of {valid, id[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 loads {transfer, i} every edge; the stages shift every edge.
  - Tail valid at edge E0+FPU_LAT+1 (E0 = transfer edge) sets `rsp_valid[id]` and captures `fpu_result`/`fpu_flags` into `rsp_result`/`rsp_flags`.
- **Response.** No backpressure; the requester must accept in that cycle. Between strobes, `rsp_result`/`rsp_flags` hold their last value.
- **`busy`** = OR of all tag-stage valid bits.
- **FSM states:**
  - RUN: `flush_req`=1 → DRAIN.
  - DRAIN: no grants; when `busy`=0 → FLUSHED.
  - FLUSHED: `flush_done`=1; `flush_req`=0 → RUN.
  - `flush_done` is registered and is 1 only in FLUSHED.
- **Reset** (asynchronous, any time, including mid-operation):
  - Outputs: `fpu_*`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0, `flush_done`=0, `busy`=0, `req_ready`=0 while reset is asserted.
  - Internal: state=RUN, `rr_ptr`=0, all tags cleared.
  - In-flight results are discarded, never delivered.

## Timing
- Latency: transfer edge E0 → `rsp_valid` high for the single cycle following edge E0+FPU_LAT+1.
- Throughput: 1 op/cycle sustained; back-to-back responses on consecutive cycles.
- `flush_req` rising while a request is valid blocks grant in that same cycle (combinational).
- Minimum drain time: FPU_LAT+1 edges after the last transfer until `busy`=0; `flush_done` rises one edge later.
- Response order equals issue order; fixed latency means no reordering.

## Configuration
- `FPU_ARB_STATS_EN` defined:
  - Adds output `grant_cnt` (NUM_REQ*16): per-requester 16-bit transfer counters.
  - Counters saturate at 16'hFFFF, are cleared by reset, and are also cleared on FLUSHED→RUN.
- Undefined: the port and counters are absent; all other behaviour is identical.

## Test plan
- Single requester 1, opa=32'h3F800000, opb=32'h40000000, op=add, rmode=0 → `rsp_valid`=4'b0010 exactly FPU_LAT+1 edges later, `rsp_result`=32'h40400000, `rsp_flags`=8'h00.
- All 4 requesters valid continuously for 8 cycles from reset → grants 0,1,2,3,0,1,2,3; each `rsp_valid` one-hot in the same order, one per cycle.
- Requesters 1 and 3 only, with `rr_ptr`=2 → grant 3, then 1, then 3; requester 0 and 2 `rsp_valid` never asserts.
- Issue 3 ops back-to-back then raise `flush_req` with requester 2 still valid → requester 2 not granted; `busy` falls after the 3rd response; `flush_done`=1 the next edge; drop `flush_req` → requester 2 granted the following cycle.
- Reset asserted 1 cycle after 2 transfers → no `rsp_valid` ever seen for them; all outputs 0; after release, the first grant goes to the lowest-index valid requester.
- opb=0, op=div → response carries `rsp_flags` div_by_zero bit (bit 0) set, routed to the issuing requester only.
